// File: rtl/lowfreq_counter_core.sv
// Gated rising-edge counter for a slow asynchronous sensor signal.
// Counts synchronised sense_in edges over gate_len clock cycles and registers the result.
module lowfreq_counter_core #(
  parameter int CNT_WIDTH   = 32,
  parameter int GATE_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_aresetn,
  input  logic                  ctrl_start,
  input  logic                  ctrl_clear,
  input  logic [GATE_WIDTH-1:0] gate_len,
  input  logic                  sense_in,
  output logic [CNT_WIDTH-1:0]  result,
  output logic                  result_valid,
  output logic                  busy,
  output logic                  overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;
  localparam logic [GATE_WIDTH-1:0] GATE_ONE = 1;

  state_t                  state;
  state_t                  state_next;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    delay_q;
  logic                    rise;
  logic [GATE_WIDTH-1:0]   timer;
  logic [CNT_WIDTH-1:0]    edge_cnt;
  logic                    ovf_int;

  // Synchroniser plus one delay stage; edge detection runs in every state so
  // a level that is already high when a window opens produces no count.
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      sync_q  <= '0;
      delay_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage see the previous cycle's value, forming a real shift chain.
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sense_in};
      delay_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~delay_q;

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    if (ctrl_clear) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (ctrl_start) state_next = (gate_len == '0) ? DONE : COUNT;
        COUNT:   if (timer == GATE_ONE) state_next = DONE;
        DONE:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn || ctrl_clear) begin
      timer        <= '0;
      edge_cnt     <= '0;
      ovf_int      <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ctrl_start) begin
            timer        <= gate_len;
            edge_cnt     <= '0;
            ovf_int      <= 1'b0;
            result_valid <= 1'b0;
            busy         <= (gate_len != '0);
          end
        end
        COUNT: begin
          timer <= timer - GATE_ONE;
          // Saturate rather than wrap; the lost edge is recorded as overflow.
          if (rise) begin
            if (edge_cnt == '1) ovf_int  <= 1'b1;
            else                edge_cnt <= edge_cnt + CNT_ONE;
          end
        end
        DONE: begin
          result       <= edge_cnt;
          overflow     <= ovf_int;
          result_valid <= 1'b1;
          busy         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
